// File: rtl/pipe_stage_hs_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg: shared definitions for the pipe_stage_hs pipeline register.
//   occ_e          occupancy/state encoding (EMPTY=0, FULL=1, SKID=2)
//   *_W_DEF        default payload / control / bubble-counter widths
//   cnt_saturated  true when a counter of the given width is at its maximum
// -----------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_FULL  = 2'd1,
        OCC_SKID  = 2'd2
    } occ_e;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned CTRL_W_DEF = 8;
    localparam int unsigned CNT_W_DEF  = 16;

    // cnt is the counter value zero-extended to 64 bits; width is its real width.
    function automatic logic cnt_saturated(input logic [63:0] cnt, input int unsigned width);
        logic [63:0] max_v;
        max_v = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return cnt == max_v;
    endfunction

endpackage

// File: rtl/pipe_stage_hs_if.sv
// -----------------------------------------------------------------------------
// pipe_stage_hs_if: one valid/ready beat channel (payload + control field).
//   valid  beat present          (master -> slave)
//   ready  beat accepted         (slave  -> master)
//   data   opaque payload        (master -> slave)
//   ctrl   control field         (master -> slave)
// -----------------------------------------------------------------------------
interface pipe_stage_hs_if
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CTRL_W = CTRL_W_DEF
) ();

    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;

    modport master (output valid, output data, output ctrl, input  ready);
    modport slave  (input  valid, input  data, input  ctrl, output ready);

endinterface

// File: rtl/pipe_stage_hs_skid_slot.sv
// -----------------------------------------------------------------------------
// pipe_skid_slot: a single valid + data + ctrl storage entry.
//   clock, reset_0        rising-edge clock, async active-low reset
//   load                  capture load_data/load_ctrl, set valid
//   clear                 drop the entry (valid=0, ctrl=0, data held); wins over load
//   load_data, load_ctrl  value captured on load
//   valid, data, ctrl     stored entry
// -----------------------------------------------------------------------------
module pipe_skid_slot #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 8
) (
    input  logic              clock,
    input  logic              reset_0,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] load_data,
    input  logic [CTRL_W-1:0] load_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    // ctrl is zeroed whenever the entry is dropped so an empty slot is a bubble;
    // data is left as-is to avoid needless toggling.
    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            ctrl  <= load_ctrl;
        end
    end

endmodule

// File: rtl/pipe_stage_hs.sv
// -----------------------------------------------------------------------------
// pipe_stage_hs: inter-stage pipeline register with valid/ready handshake,
// flush and a saturating starvation counter.
//   clock       rising-edge clock
//   reset_0     async active-low reset
//   up          upstream channel (slave): in_valid/in_ready/in_data/in_ctrl
//   dn          downstream channel (master): out_valid/out_ready/out_data/out_ctrl
//   flush       synchronous kill of every held beat, highest priority
//   occupancy   beats held (0, 1, or 2 with skid)
//   bubble_cnt  cycles with downstream ready and nothing to give, saturating
// Build option: define PIPE_STAGE_SKID_EN for the 2-entry variant whose
// in_ready comes straight from a flop; otherwise 1-entry with a combinational
// in_ready = !out_valid | out_ready.
// -----------------------------------------------------------------------------
module pipe_stage_hs
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CTRL_W = CTRL_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset_0,
    pipe_stage_hs_if.slave   up,
    pipe_stage_hs_if.master  dn,
    input  logic             flush,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] bubble_cnt
);

    occ_e              state_q;
    occ_e              state_d;
    logic              in_ready;
    logic              accept;
    logic              emit;

    logic              main_valid;
    logic              main_load;
    logic              main_clear;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_src_data;
    logic [CTRL_W-1:0] main_src_ctrl;

    logic [CNT_W-1:0]  bubble_q;

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_valid;
    logic              skid_load;
    logic              skid_clear;
    logic              main_from_skid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    // Ready depends only on the skid flop, so no path from dn.ready to up.ready.
    assign in_ready      = ~skid_valid;
    assign main_src_data = main_from_skid ? skid_data : up.data;
    assign main_src_ctrl = main_from_skid ? skid_ctrl : up.ctrl;
`else
    assign in_ready      = ~main_valid | dn.ready;
    assign main_src_data = up.data;
    assign main_src_ctrl = up.ctrl;
`endif

    assign up.ready = in_ready;
    assign accept   = up.valid & in_ready;
    assign emit     = main_valid & dn.ready;

    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) begin
            state_q <= OCC_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        main_load  = 1'b0;
        main_clear = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        main_from_skid = 1'b0;
`endif
        if (flush) begin
            state_d    = OCC_EMPTY;
            main_clear = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
            skid_clear = 1'b1;
`endif
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    if (accept) begin
                        main_load = 1'b1;
                        state_d   = OCC_FULL;
                    end
                end
                OCC_FULL: begin
                    if (accept && emit) begin
                        main_load = 1'b1;
                    end else if (emit) begin
                        main_clear = 1'b1;
                        state_d    = OCC_EMPTY;
                    end
`ifdef PIPE_STAGE_SKID_EN
                    else if (accept) begin
                        skid_load = 1'b1;
                        state_d   = OCC_SKID;
                    end
`endif
                end
`ifdef PIPE_STAGE_SKID_EN
                OCC_SKID: begin
                    // Older beat leaves main; skid beat moves up so order is kept.
                    if (emit) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                        state_d        = OCC_FULL;
                    end
                end
`endif
                default: begin
                    state_d    = OCC_EMPTY;
                    main_clear = 1'b1;
                end
            endcase
        end
    end

    pipe_skid_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .clock     (clock),
        .reset_0   (reset_0),
        .load      (main_load),
        .clear     (main_clear),
        .load_data (main_src_data),
        .load_ctrl (main_src_ctrl),
        .valid     (main_valid),
        .data      (main_data),
        .ctrl      (main_ctrl)
    );

`ifdef PIPE_STAGE_SKID_EN
    pipe_skid_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_skid (
        .clock     (clock),
        .reset_0   (reset_0),
        .load      (skid_load),
        .clear     (skid_clear),
        .load_data (up.data),
        .load_ctrl (up.ctrl),
        .valid     (skid_valid),
        .data      (skid_data),
        .ctrl      (skid_ctrl)
    );
`endif

    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) begin
            bubble_q <= '0;
        end else if (dn.ready && !main_valid &&
                     !cnt_saturated(64'(bubble_q), CNT_W)) begin
            bubble_q <= bubble_q + CNT_W'(1);
        end
    end

    assign dn.valid   = main_valid;
    assign dn.data    = main_data;
    assign dn.ctrl    = main_ctrl;
    assign occupancy  = state_q;
    assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_hs: directed bench for pipe_stage_hs with a beat scoreboard.
// Expectations adapt to PIPE_STAGE_SKID_EN (2-entry) vs. default (1-entry).
// A second instance with a 4-bit bubble counter covers saturation.
// -----------------------------------------------------------------------------
module tb_pipe_stage_hs;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 8;
`ifdef PIPE_STAGE_SKID_EN
    localparam int unsigned MAX_OCC = 2;
`else
    localparam int unsigned MAX_OCC = 1;
`endif

    logic        clock   = 1'b0;
    logic        reset_0 = 1'b0;
    logic        flush   = 1'b0;
    logic        s_flush = 1'b0;
    logic [1:0]  occupancy;
    logic [1:0]  s_occupancy;
    logic [15:0] bubble_cnt;
    logic [3:0]  s_bubble_cnt;

    always #5 clock = ~clock;

    pipe_stage_hs_if #(.DATA_W(DW), .CTRL_W(CW)) up_if ();
    pipe_stage_hs_if #(.DATA_W(DW), .CTRL_W(CW)) dn_if ();
    pipe_stage_hs_if #(.DATA_W(DW), .CTRL_W(CW)) s_up_if ();
    pipe_stage_hs_if #(.DATA_W(DW), .CTRL_W(CW)) s_dn_if ();

    pipe_stage_hs #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16)) dut (
        .clock      (clock),
        .reset_0    (reset_0),
        .up         (up_if),
        .dn         (dn_if),
        .flush      (flush),
        .occupancy  (occupancy),
        .bubble_cnt (bubble_cnt)
    );

    pipe_stage_hs #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(4)) dut_small (
        .clock      (clock),
        .reset_0    (reset_0),
        .up         (s_up_if),
        .dn         (s_dn_if),
        .flush      (s_flush),
        .occupancy  (s_occupancy),
        .bubble_cnt (s_bubble_cnt)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [CW-1:0] ctrl;
    } beat_t;

    beat_t       sb[$];
    int unsigned exp_occ = 0;
    logic [15:0] exp_bub = '0;
    int          checks  = 0;
    int          errors  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called half a cycle before a rising edge with inputs already driven:
    // checks the visible state against the model, then advances the model by
    // the upcoming edge and waits until the following falling edge.
    task automatic tick();
        logic  exp_ready;
        logic  acc;
        logic  emt;
        beat_t b;
        #1;
        exp_ready = (MAX_OCC == 2) ? (exp_occ < 2) : (exp_occ == 0 || dn_if.ready);
        check("in_ready",   64'(up_if.ready), 64'(exp_ready));
        check("out_valid",  64'(dn_if.valid), 64'(exp_occ != 0));
        check("occupancy",  64'(occupancy),   64'(exp_occ));
        check("bubble_cnt", 64'(bubble_cnt),  64'(exp_bub));
        if (exp_occ != 0) begin
            check("out_data", 64'(dn_if.data), 64'(sb[0].data));
            check("out_ctrl", 64'(dn_if.ctrl), 64'(sb[0].ctrl));
        end else begin
            check("out_ctrl_idle", 64'(dn_if.ctrl), 64'd0);
        end
        acc = up_if.valid & exp_ready;
        emt = (exp_occ != 0) && dn_if.ready;
        if (dn_if.ready && exp_occ == 0 && exp_bub != 16'hFFFF) exp_bub++;
        if (flush) begin
            sb.delete();
            exp_occ = 0;
        end else begin
            if (emt) begin
                void'(sb.pop_front());
                exp_occ--;
            end
            if (acc) begin
                b.data = up_if.data;
                b.ctrl = up_if.ctrl;
                sb.push_back(b);
                exp_occ++;
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] bub_start;

        up_if.valid   = 1'b1;
        up_if.data    = 32'hDEAD_BEEF;
        up_if.ctrl    = 8'h3C;
        dn_if.ready   = 1'b0;
        s_up_if.valid = 1'b0;
        s_up_if.data  = '0;
        s_up_if.ctrl  = '0;
        s_dn_if.ready = 1'b0;

        // Reset held with a beat presented upstream.
        repeat (2) @(negedge clock);
        #1;
        check("rst_out_valid",  64'(dn_if.valid),  64'd0);
        check("rst_out_ctrl",   64'(dn_if.ctrl),   64'd0);
        check("rst_occupancy",  64'(occupancy),    64'd0);
        check("rst_bubble_cnt", 64'(bubble_cnt),   64'd0);
        check("rst_s_bubble",   64'(s_bubble_cnt), 64'd0);
        @(negedge clock);
        reset_0     = 1'b1;
        up_if.valid = 1'b0;

        // Streaming beats 1..8 back to back.
        dn_if.ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            up_if.valid = 1'b1;
            up_if.data  = 32'(i);
            up_if.ctrl  = 8'(i);
            tick();
        end
        up_if.valid = 1'b0;
        repeat (2) tick();

        // Stall with a second beat behind it.
        dn_if.ready = 1'b0;
        up_if.valid = 1'b1;
        up_if.data  = 32'h5A;
        up_if.ctrl  = 8'h81;
        tick();
        up_if.data  = 32'hA5;
        up_if.ctrl  = 8'h82;
        repeat (4) tick();
`ifdef PIPE_STAGE_SKID_EN
        up_if.valid = 1'b0;
`endif
        dn_if.ready = 1'b1;
        tick();
        up_if.valid = 1'b0;
        repeat (3) tick();

        // Flush with a full stage and a beat offered in the flush cycle.
        dn_if.ready = 1'b0;
        up_if.valid = 1'b1;
        up_if.data  = 32'h11;
        up_if.ctrl  = 8'h01;
        tick();
        up_if.data  = 32'h22;
        up_if.ctrl  = 8'h02;
        tick();
        flush       = 1'b1;
        up_if.data  = 32'h33;
        up_if.ctrl  = 8'hFF;
        tick();
        flush       = 1'b0;
        up_if.valid = 1'b0;
        tick();
        check("flush_data_hold", 64'(dn_if.data), 64'h11);
        dn_if.ready = 1'b1;
        repeat (2) tick();

        // Starvation: both counters run for 10 then 20 cycles.
        bub_start     = exp_bub;
        s_dn_if.ready = 1'b1;
        repeat (10) tick();
        check("bubble_plus10", 64'(bubble_cnt),   64'(bub_start + 16'd10));
        check("small_bub_10",  64'(s_bubble_cnt), 64'd10);
        repeat (10) tick();
        check("small_bub_sat", 64'(s_bubble_cnt), 64'd15);
        s_dn_if.ready = 1'b0;

        // Reset dropped between edges while the stage is stalled and full.
        dn_if.ready = 1'b0;
        up_if.valid = 1'b1;
        up_if.data  = 32'h44;
        up_if.ctrl  = 8'h04;
        tick();
        up_if.data  = 32'h55;
        up_if.ctrl  = 8'h05;
        tick();
        #3;
        reset_0 = 1'b0;
        #1;
        check("midrst_out_valid", 64'(dn_if.valid), 64'd0);
        check("midrst_occupancy", 64'(occupancy),   64'd0);
        check("midrst_out_ctrl",  64'(dn_if.ctrl),  64'd0);
        up_if.valid = 1'b0;
        @(negedge clock);
        reset_0 = 1'b1;
        sb.delete();
        exp_occ = 0;
        exp_bub = '0;
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
